display_nhex: RTL and testbench
===============================

DISPLAY_NHEX -- requirements
Module: display_nhex

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of hex digits scanned (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 16384: clk cycles each digit is held (legal >= 2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: frames per blink half-period (used only with DISPLAY_BLINK_EN).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data  input  4*DIGITS  hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-007 dp  input  DIGITS  decimal-point enable per digit, 1 = lit.
REQ-008 blank_lz  input  1  1 = blank leading zero digits.
REQ-009 load  input  1  single-cycle strobe capturing data, dp and blank_lz.
REQ-010 load_pending  output  1  captured value not yet on display.
REQ-011 seg  output  7  segments, active-low, seg[0]=a … seg[6]=g.
REQ-012 dp_n  output  1  decimal point, active-low.
REQ-013 strobe  output  DIGITS  digit anodes, active-low, at most one low per cycle.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be asserted in the wrap cycle.
REQ-015 Digit index SHALL advance 0,1,…,DIGITS-1,0 on each tick; a tick while index=DIGITS-1 SHALL be the frame-end tick.
REQ-016 load SHALL copy data/dp/blank_lz into a pending register and set load_pending on the next edge; a later load before frame end SHALL overwrite pending.
REQ-017 On frame-end tick, if load_pending=1, pending SHALL copy into the active register and load_pending SHALL clear.
REQ-018 load coinciding with frame-end tick SHALL write the load inputs directly to active and leave load_pending=0.
REQ-019 Active register SHALL change only at frame-end ticks; the display SHALL never tear mid-frame.
REQ-020 seg, dp_n, strobe SHALL be registered, reflecting the current index and active register with 1-cycle latency.
REQ-021 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (g..a).
REQ-022 With active blank_lz=1, a digit SHALL be blanked (seg=1111111) when it and every higher digit are 0; digit 0 SHALL never be blanked.
REQ-023 A blanked digit SHALL keep its strobe low and dp_n = ~dp[i].
REQ-024 Each digit SHALL be on for exactly REFRESH_DIV cycles; frame period SHALL be DIGITS*REFRESH_DIV cycles.

Reset
REQ-025 reset SHALL set prescaler=0, index=0, active and pending data/dp/blank_lz=0, load_pending=0, blink state=0.
REQ-026 Outputs during reset SHALL be seg=1111111, dp_n=1, strobe all 1.
REQ-027 The first edge after reset deasserts SHALL drive strobe[0]=0, seg=1000000.
REQ-028 reset SHALL take priority over load and any tick; a load coincident with reset SHALL be discarded.

Configuration
REQ-029 Macro DISPLAY_BLINK_EN SHALL compile in per-digit blinking.
REQ-030 With DISPLAY_BLINK_EN: input blink (DIGITS wide) SHALL be captured by load alongside data; a frame counter SHALL toggle blink phase every BLINK_FRAMES frame-end ticks; in phase 1, digits with active blink[i]=1 SHALL show seg=1111111 and dp_n=1, strobe unchanged.
REQ-031 Without DISPLAY_BLINK_EN: no blink port, no frame counter, no blink logic; behaviour SHALL be as REQ-014..REQ-028.

Verification (DIGITS=8, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-032 Reset, load data=0x01234567 dp=0 -> load_pending=1 until frame end; next frame digit 0 shows seg=1111000 (strobe=11111110), digit 7 shows 1000000 for 4 cycles each.
REQ-033 Load data=0x00000A05 blank_lz=1 -> digits 7..3 seg=1111111, digit 2=0001000, digit 1=1000000, digit 0=0010010.
REQ-034 Load at index 3 -> seg for indices 4..7 still show old data, load_pending=1; new data from index 0 of next frame.
REQ-035 Load in the frame-end tick cycle -> load_pending stays 0, new data shown at index 0 of the following frame.
REQ-036 reset asserted at index 5 for one cycle -> next edge all outputs at REQ-026 values, index 0 and load_pending=0 afterwards.
REQ-037 With DISPLAY_BLINK_EN, blink=0x01 -> digit 0 on in frames 0-1, blank in 2-3, on in 4-5; other digits always on.

Source files
------------

// File: rtl/display_nhex.sv
// Multiplexed N-digit hex 7-segment display driver.
// A prescaler divides clk into digit ticks, and a digit index scans the digits
// right to left. New values are staged in a pending register and promoted only
// at the frame end, so a frame never mixes old and new digits.
// Optional feature: define DISPLAY_BLINK_EN to add per-digit blinking.
module display_nhex #(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned REFRESH_DIV  = 16384,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  blank_lz,
   input  logic                  load,
`ifdef DISPLAY_BLINK_EN
   input  logic [DIGITS-1:0]     blink,
`endif
   output logic                  load_pending,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     strobe
);

   localparam int unsigned CntW = $clog2(REFRESH_DIV);
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Reject out-of-range parameters at elaboration.
   if (DIGITS < 1 || DIGITS > 8 || REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_err
      $error("display_nhex: illegal parameter value");
   end

   // Active-low segment patterns, bit order g..a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      unique case (nib)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic                tick, frame_end;

   logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic                pend_blz_q, pend_blz_d, act_blz_q, act_blz_d;
   logic                pend_vld_q, pend_vld_d;

   logic [6:0]          seg_q, seg_d;
   logic                dp_n_q, dp_n_d;
   logic [DIGITS-1:0]   strobe_q, strobe_d;

`ifdef DISPLAY_BLINK_EN
   localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
   logic [FrmW-1:0]     frm_cnt_q, frm_cnt_d;
   logic                phase_q, phase_d;
`endif

   // Prescaler, digit scan and pending/active register next state.
   always_comb begin
      tick        = (cnt_q == CntW'(REFRESH_DIV - 1));
      frame_end   = tick && (idx_q == IdxW'(DIGITS - 1));
      cnt_d       = tick ? '0 : cnt_q + CntW'(1);
      idx_d       = idx_q;
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      pend_blz_d  = pend_blz_q;
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      act_blz_d   = act_blz_q;
      pend_vld_d  = pend_vld_q;
`ifdef DISPLAY_BLINK_EN
      pend_blink_d = pend_blink_q;
      act_blink_d  = act_blink_q;
      frm_cnt_d    = frm_cnt_q;
      phase_d      = phase_q;
`endif

      if (tick) begin
         idx_d = frame_end ? '0 : idx_q + IdxW'(1);
      end

      if (load && frame_end) begin
         // Load landing on the frame boundary bypasses the pending stage.
         act_data_d = data;
         act_dp_d   = dp;
         act_blz_d  = blank_lz;
         pend_vld_d = 1'b0;
`ifdef DISPLAY_BLINK_EN
         act_blink_d = blink;
`endif
      end else if (load) begin
         pend_data_d = data;
         pend_dp_d   = dp;
         pend_blz_d  = blank_lz;
         pend_vld_d  = 1'b1;
`ifdef DISPLAY_BLINK_EN
         pend_blink_d = blink;
`endif
      end else if (frame_end && pend_vld_q) begin
         act_data_d = pend_data_q;
         act_dp_d   = pend_dp_q;
         act_blz_d  = pend_blz_q;
         pend_vld_d = 1'b0;
`ifdef DISPLAY_BLINK_EN
         act_blink_d = pend_blink_q;
`endif
      end

`ifdef DISPLAY_BLINK_EN
      if (frame_end) begin
         if (frm_cnt_q == FrmW'(BLINK_FRAMES - 1)) begin
            frm_cnt_d = '0;
            phase_d   = ~phase_q;
         end else begin
            frm_cnt_d = frm_cnt_q + FrmW'(1);
         end
      end
`endif
   end

   // Output decode for the digit currently selected by idx_q.
   always_comb begin
      logic [3:0]        nib;
      logic              dp_sel;
      logic              lz_sel;
      logic              all_zero;
      logic [DIGITS-1:0] lz;
`ifdef DISPLAY_BLINK_EN
      logic              blink_sel;
      blink_sel = 1'b0;
`endif
      nib      = 4'h0;
      dp_sel   = 1'b0;
      lz_sel   = 1'b0;
      all_zero = 1'b1;
      lz       = '0;
      strobe_d = '1;

      // lz[i] is set when digit i and every higher digit are zero.
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         all_zero = all_zero & (act_data_q[4*i +: 4] == 4'h0);
         lz[i]    = all_zero;
      end

      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            nib         = act_data_q[4*i +: 4];
            dp_sel      = act_dp_q[i];
            lz_sel      = lz[i] && (i != 0);
            strobe_d[i] = 1'b0;
`ifdef DISPLAY_BLINK_EN
            blink_sel   = act_blink_q[i];
`endif
         end
      end

      seg_d  = (act_blz_q && lz_sel) ? 7'h7F : hex_to_seg(nib);
      dp_n_d = ~dp_sel;
`ifdef DISPLAY_BLINK_EN
      if (phase_q && blink_sel) begin
         seg_d  = 7'h7F;
         dp_n_d = 1'b1;
      end
`endif
   end

   // State and registered outputs; reset wins over load and tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         pend_blz_q  <= 1'b0;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         act_blz_q   <= 1'b0;
         pend_vld_q  <= 1'b0;
         seg_q       <= 7'h7F;
         dp_n_q      <= 1'b1;
         strobe_q    <= '1;
`ifdef DISPLAY_BLINK_EN
         pend_blink_q <= '0;
         act_blink_q  <= '0;
         frm_cnt_q    <= '0;
         phase_q      <= 1'b0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pend_data_q <= pend_data_d;
         pend_dp_q   <= pend_dp_d;
         pend_blz_q  <= pend_blz_d;
         act_data_q  <= act_data_d;
         act_dp_q    <= act_dp_d;
         act_blz_q   <= act_blz_d;
         pend_vld_q  <= pend_vld_d;
         seg_q       <= seg_d;
         dp_n_q      <= dp_n_d;
         strobe_q    <= strobe_d;
`ifdef DISPLAY_BLINK_EN
         pend_blink_q <= pend_blink_d;
         act_blink_q  <= act_blink_d;
         frm_cnt_q    <= frm_cnt_d;
         phase_q      <= phase_d;
`endif
      end
   end

   assign load_pending = pend_vld_q;
   assign seg          = seg_q;
   assign dp_n         = dp_n_q;
   assign strobe       = strobe_q;

endmodule

// File: tb/tb_display_nhex.sv
// Directed bench for display_nhex with DIGITS=8, REFRESH_DIV=4, BLINK_FRAMES=2.
// k counts rising edges since reset release; outputs seen after edge k show
// digit ((k-1)/4)%8 of the register that was active before that edge.
module tb_display_nhex;

   localparam int unsigned DIGITS       = 8;
   localparam int unsigned REFRESH_DIV  = 4;
   localparam int unsigned BLINK_FRAMES = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp;
   logic                blank_lz;
   logic                load;
   logic                load_pending;
   logic [6:0]          seg;
   logic                dp_n;
   logic [DIGITS-1:0]   strobe;
`ifdef DISPLAY_BLINK_EN
   logic [DIGITS-1:0]   blink;
`endif

   int checks = 0;
   int errors = 0;
   int k      = 0;

   display_nhex #(
      .DIGITS       (DIGITS),
      .REFRESH_DIV  (REFRESH_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .data         (data),
      .dp           (dp),
      .blank_lz     (blank_lz),
      .load         (load),
`ifdef DISPLAY_BLINK_EN
      .blink        (blink),
`endif
      .load_pending (load_pending),
      .seg          (seg),
      .dp_n         (dp_n),
      .strobe       (strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic chk_out(input string tag, input logic [6:0] s, input logic [7:0] st,
                          input logic d);
      check({tag, ".seg"}, 32'(seg), 32'(s));
      check({tag, ".strobe"}, 32'(strobe), 32'(st));
      check({tag, ".dp_n"}, 32'(dp_n), 32'(d));
   endtask

   // One rising edge, then park on the falling edge for sampling and driving.
   task automatic step();
      @(posedge clk);
      k++;
      @(negedge clk);
   endtask

   task automatic run_to(input int n);
      while (k < n) step();
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic b);
      data     = d;
      dp       = p;
      blank_lz = b;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      data     = '0;
      dp       = '0;
      blank_lz = 1'b0;
      load     = 1'b0;
`ifdef DISPLAY_BLINK_EN
      blink    = '0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_out("in_reset", 7'h7F, 8'hFF, 1'b1);
      check("in_reset.pend", 32'(load_pending), 32'd0);

      reset = 1'b0;
      k     = 0;
      step();
      chk_out("first_edge", 7'h40, 8'hFE, 1'b1);

      // Pending until frame end, then 0x01234567 from the next frame.
      do_load(32'h0123_4567, 8'h00, 1'b0);
      check("ld1.pend_set", 32'(load_pending), 32'd1);
      run_to(31);
      check("ld1.pend_hold", 32'(load_pending), 32'd1);
      step();
      check("ld1.pend_clr", 32'(load_pending), 32'd0);
      step();
      chk_out("ld1.d0_first", 7'h78, 8'hFE, 1'b1);
      run_to(36);
      chk_out("ld1.d0_last", 7'h78, 8'hFE, 1'b1);
      step();
      chk_out("ld1.d1", 7'h02, 8'hFD, 1'b1);
      run_to(61);
      chk_out("ld1.d7_first", 7'h40, 8'h7F, 1'b1);
      run_to(64);
      chk_out("ld1.d7_last", 7'h40, 8'h7F, 1'b1);

      // Leading-zero blanking; dp on blanked digit 7 still lit.
      do_load(32'h0000_0A05, 8'h80, 1'b1);
      check("lz.pend_set", 32'(load_pending), 32'd1);
      run_to(97);
      chk_out("lz.d0", 7'h12, 8'hFE, 1'b1);
      run_to(101);
      chk_out("lz.d1", 7'h40, 8'hFD, 1'b1);
      run_to(105);
      chk_out("lz.d2", 7'h08, 8'hFB, 1'b1);
      run_to(109);
      chk_out("lz.d3", 7'h7F, 8'hF7, 1'b1);
      run_to(125);
      chk_out("lz.d7", 7'h7F, 8'h7F, 1'b0);

      // Load mid-frame at index 3: rest of frame keeps old data.
      run_to(141);
      chk_out("mid.d3_old", 7'h7F, 8'hF7, 1'b1);
      do_load(32'h1111_1111, 8'h00, 1'b0);
      check("mid.pend_set", 32'(load_pending), 32'd1);
      run_to(145);
      chk_out("mid.d4_old", 7'h7F, 8'hEF, 1'b1);
      run_to(157);
      chk_out("mid.d7_old", 7'h7F, 8'h7F, 1'b0);
      check("mid.pend_hold", 32'(load_pending), 32'd1);
      run_to(160);
      check("mid.pend_clr", 32'(load_pending), 32'd0);
      step();
      chk_out("mid.d0_new", 7'h79, 8'hFE, 1'b1);

      // Load in the frame-end tick cycle goes straight to active.
      run_to(191);
      do_load(32'h0000_000E, 8'h01, 1'b0);
      check("fe.pend_zero", 32'(load_pending), 32'd0);
      step();
      chk_out("fe.d0_new", 7'h06, 8'hFE, 1'b0);
      check("fe.pend_still0", 32'(load_pending), 32'd0);

      // Reset at index 5 with a pending value and a coincident load.
      do_load(32'h2222_2222, 8'h00, 1'b0);
      check("rst.pend_set", 32'(load_pending), 32'd1);
      run_to(213);
      chk_out("rst.d5_pre", 7'h40, 8'hDF, 1'b1);
      reset = 1'b1;
      load  = 1'b1;
      data  = 32'h3333_3333;
      step();
      chk_out("rst.outputs", 7'h7F, 8'hFF, 1'b1);
      check("rst.pend", 32'(load_pending), 32'd0);
      reset = 1'b0;
      load  = 1'b0;
      k     = 0;
      step();
      chk_out("rst.idx0", 7'h40, 8'hFE, 1'b1);
      check("rst.pend_after", 32'(load_pending), 32'd0);
      run_to(33);
      chk_out("rst.load_dropped", 7'h40, 8'hFE, 1'b1);

`ifdef DISPLAY_BLINK_EN
      // Blink on digit 0: phase toggles at the ends of frames 1 and 3.
      blink = 8'h01;
      do_load(32'h0000_0000, 8'h01, 1'b0);
      blink = 8'h00;
      run_to(65);
      chk_out("blk.f2_d0", 7'h7F, 8'hFE, 1'b1);
      run_to(69);
      chk_out("blk.f2_d1", 7'h40, 8'hFD, 1'b1);
      run_to(97);
      chk_out("blk.f3_d0", 7'h7F, 8'hFE, 1'b1);
      run_to(129);
      chk_out("blk.f4_d0", 7'h40, 8'hFE, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
